// File: rtl/approx_prod_accum.sv
// Streaming frame accumulator for 16-bit approximate-multiplier products.
// Define APPROX_ACC_SATURATE_EN to clamp the running sum at all-ones instead of wrapping.
module approx_prod_accum #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [LEN_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic {
        ST_ACC,
        ST_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [LEN_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic               accept;
    logic [ACC_W:0]     sum_ext;
    logic               carry;
    logic [ACC_W-1:0]   acc_res;
    logic [LEN_W-1:0]   cnt_inc;
    logic               ovf_inc;
    logic               frame_end;

    assign in_ready = (state_q == ST_ACC);
    assign accept   = in_valid && in_ready;

    assign sum_ext  = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, in_prod};
    assign carry    = sum_ext[ACC_W];
    assign ovf_inc  = ovf_q | carry;
    assign cnt_inc  = cnt_q + 1'b1;

`ifdef APPROX_ACC_SATURATE_EN
    // Once clamped, any further nonzero term carries again, so the clamp is sticky.
    assign acc_res  = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_res  = sum_ext[ACC_W-1:0];
`endif

    // A frame is forced closed when the counter would reach its all-ones limit.
    assign frame_end = in_last || (cnt_inc == {LEN_W{1'b1}});

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (frame_end) begin
                        out_sum_d   = acc_res;
                        out_count_d = cnt_inc;
                        out_ovf_d   = ovf_inc;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = ST_HOLD;
                    end else begin
                        acc_d = acc_res;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_inc;
                    end
                end
            end
            ST_HOLD: begin
                // Result fields are left intact after the handshake.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_approx_prod_accum.sv
// Directed and randomized bench for approx_prod_accum: a default instance and a
// narrow instance (ACC_W=16, LEN_W=3) for overflow and forced-termination cases.
module tb_approx_prod_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_ovf;
    logic [15:0] a_in_prod;
    logic [23:0] a_out_sum;
    logic [7:0]  a_out_count;

    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
    logic [15:0] b_in_prod;
    logic [15:0] b_out_sum;
    logic [2:0]  b_out_count;

    approx_prod_accum #(.ACC_W(24), .LEN_W(8)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_prod(a_in_prod), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum),
        .out_count(a_out_count), .out_ovf(a_out_ovf)
    );

    approx_prod_accum #(.ACC_W(16), .LEN_W(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
        .out_count(b_out_count), .out_ovf(b_out_ovf)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [23:0] sum;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   rx_frames;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic push(input int sel, input logic [15:0] p, input logic last);
        int   w = 0;
        logic rdy;
        if (sel == 0) begin
            a_in_valid = 1'b1; a_in_prod = p; a_in_last = last;
        end else begin
            b_in_valid = 1'b1; b_in_prod = p; b_in_last = last;
        end
        rdy = (sel == 0) ? a_in_ready : b_in_ready;
        while (!rdy && w < 50) begin
            @(negedge clk);
            w++;
            rdy = (sel == 0) ? a_in_ready : b_in_ready;
        end
        check("push_ready", 32'(rdy), 32'd1);
        @(negedge clk);
        if (sel == 0) begin
            a_in_valid = 1'b0; a_in_last = 1'b0;
        end else begin
            b_in_valid = 1'b0; b_in_last = 1'b0;
        end
    endtask

    task automatic producer();
        int          len;
        logic [15:0] p;
        logic [31:0] s;
        exp_t        e;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 6);
            s   = 32'd0;
            for (int t = 0; t < len; t++) begin
                p = 16'($urandom);
                s = s + 32'(p);
                while ($urandom_range(0, 1) == 0) @(negedge clk);
                if (t == len - 1) begin
                    e.sum = s[23:0];
                    e.cnt = 8'(len);
                    e.ovf = (s > 32'h00FF_FFFF);
                    exp_q.push_back(e);
                end
                push(0, p, (t == len - 1));
            end
        end
    endtask

    task automatic consumer();
        int   cyc = 0;
        exp_t e;
        rx_frames = 0;
        while (rx_frames < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            a_out_ready = ($urandom_range(0, 9) < 7);
            if (a_out_valid && a_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_qsize", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_sum", 32'(a_out_sum), 32'(e.sum));
                    check("rnd_count", 32'(a_out_count), 32'(e.cnt));
                    check("rnd_ovf", 32'(a_out_ovf), 32'(e.ovf));
                    $display("rnd frame %0d sum=%h count=%0d ovf=%b", rx_frames, a_out_sum, a_out_count, a_out_ovf);
                end
                rx_frames++;
            end
        end
        check("rnd_frames", 32'(rx_frames), 32'd1000);
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_prod = '0; a_in_last = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_prod = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_valid", 32'(a_out_valid), 32'd0);
        check("rst_sum", 32'(a_out_sum), 32'd0);
        check("rst_count", 32'(a_out_count), 32'd0);
        check("rst_ovf", 32'(a_out_ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready_a", 32'(a_in_ready), 32'd1);
        check("rst_in_ready_b", 32'(b_in_ready), 32'd1);
        $display("reset done");

        // Three-term frame, with an idle gap carrying a stray in_last.
        push(0, 16'h0010, 1'b0);
        a_in_last = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_gap_valid", 32'(a_out_valid), 32'd0);
        a_in_last = 1'b0;
        push(0, 16'h0100, 1'b0);
        check("t1_mid_valid", 32'(a_out_valid), 32'd0);
        push(0, 16'hFFFF, 1'b1);
        check("t1_valid", 32'(a_out_valid), 32'd1);
        check("t1_in_ready_hold", 32'(a_in_ready), 32'd0);
        check("t1_sum", 32'(a_out_sum), 32'h0001010F);
        check("t1_count", 32'(a_out_count), 32'd3);
        check("t1_ovf", 32'(a_out_ovf), 32'd0);
        $display("t1 frame sum=%h count=%0d ovf=%b", a_out_sum, a_out_count, a_out_ovf);
        @(negedge clk);
        check("t1_valid_after", 32'(a_out_valid), 32'd0);
        check("t1_in_ready_after", 32'(a_in_ready), 32'd1);
        check("t1_sum_kept", 32'(a_out_sum), 32'h0001010F);

        // Single-term frame held under back-pressure.
        a_out_ready = 1'b0;
        push(0, 16'h1234, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 32'(a_out_valid), 32'd1);
            check("t2_hold_in_ready", 32'(a_in_ready), 32'd0);
            check("t2_hold_sum", 32'(a_out_sum), 32'h00001234);
            check("t2_hold_count", 32'(a_out_count), 32'd1);
            @(negedge clk);
        end
        $display("t2 frame sum=%h count=%0d", a_out_sum, a_out_count);
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_prod = 16'h0007; a_in_last = 1'b1;
        @(negedge clk);
        check("t2_released_valid", 32'(a_out_valid), 32'd0);
        check("t2_released_in_ready", 32'(a_in_ready), 32'd1);
        @(negedge clk);
        a_in_valid = 1'b0; a_in_last = 1'b0;
        check("t2_next_valid", 32'(a_out_valid), 32'd1);
        check("t2_next_sum", 32'(a_out_sum), 32'h00000007);
        check("t2_next_count", 32'(a_out_count), 32'd1);
        $display("t2 next frame sum=%h count=%0d", a_out_sum, a_out_count);
        @(negedge clk);

        // Narrow accumulator overflow.
        push(1, 16'hFFFF, 1'b0);
        push(1, 16'h0002, 1'b1);
`ifdef APPROX_ACC_SATURATE_EN
        check("t3_sum", 32'(b_out_sum), 32'h0000FFFF);
`else
        check("t3_sum", 32'(b_out_sum), 32'h00000001);
`endif
        check("t3_ovf", 32'(b_out_ovf), 32'd1);
        check("t3_count", 32'(b_out_count), 32'd2);
        $display("t3 frame sum=%h count=%0d ovf=%b", b_out_sum, b_out_count, b_out_ovf);

        // Forced termination at 7 terms with LEN_W=3.
        for (int i = 1; i <= 10; i++) begin
            push(1, 16'h0001, (i == 10));
            if (i == 7) begin
                check("t4_f1_valid", 32'(b_out_valid), 32'd1);
                check("t4_f1_sum", 32'(b_out_sum), 32'd7);
                check("t4_f1_count", 32'(b_out_count), 32'd7);
                check("t4_f1_ovf", 32'(b_out_ovf), 32'd0);
                $display("t4 frame1 sum=%h count=%0d", b_out_sum, b_out_count);
            end else if (i == 10) begin
                check("t4_f2_valid", 32'(b_out_valid), 32'd1);
                check("t4_f2_sum", 32'(b_out_sum), 32'd3);
                check("t4_f2_count", 32'(b_out_count), 32'd3);
                $display("t4 frame2 sum=%h count=%0d", b_out_sum, b_out_count);
            end else begin
                check("t4_mid_valid", 32'(b_out_valid), 32'd0);
            end
        end
        @(negedge clk);

        // Random gaps and stalls against a reference sum model.
        fork
            producer();
            consumer();
        join
        a_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rnd_leftover", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-frame.
        push(0, 16'h0011, 1'b0);
        push(0, 16'h0022, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(a_out_valid), 32'd0);
        check("t6_rst_sum", 32'(a_out_sum), 32'd0);
        check("t6_rst_count", 32'(a_out_count), 32'd0);
        check("t6_rst_ovf", 32'(a_out_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push(0, 16'h0005, 1'b1);
        check("t6_valid", 32'(a_out_valid), 32'd1);
        check("t6_sum", 32'(a_out_sum), 32'd5);
        check("t6_count", 32'(a_out_count), 32'd1);
        $display("t6 frame sum=%h count=%0d", a_out_sum, a_out_count);
        @(negedge clk);

        // Asynchronous reset while holding a result.
        a_out_ready = 1'b0;
        push(0, 16'h0009, 1'b1);
        check("t7_hold_valid", 32'(a_out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t7_rst_valid", 32'(a_out_valid), 32'd0);
        check("t7_rst_in_ready", 32'(a_in_ready), 32'd1);
        check("t7_rst_sum", 32'(a_out_sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        a_out_ready = 1'b1;
        push(0, 16'h0003, 1'b1);
        check("t7_sum", 32'(a_out_sum), 32'd3);
        check("t7_count", 32'(a_out_count), 32'd1);
        $display("t7 frame sum=%h count=%0d", a_out_sum, a_out_count);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/approx_prod_accum.md
Name: approx_prod_accum

Overview:
- Streaming accumulator directly downstream of the 8x8 LUT-based approximate multiplier.
- Accepts its 16-bit products over a valid/ready handshake and sums a frame of products, delimited by in_last or by a term-count limit.
- Presents the frame sum, the term count and an overflow flag on a registered output handshake.
- Forms the accumulate half of the approximate MAC datapath.

Parameters:
- ACC_W, 24, accumulator and out_sum width in bits; minimum 16.
- LEN_W, 8, term-counter width; a frame is at most 2^LEN_W-1 terms.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_prod/in_last valid.
- in_ready  output  1  block can accept a product this cycle.
- in_prod  input  16  unsigned product from the approximate multiplier.
- in_last  input  1  final term of the current frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  accumulated frame sum.
- out_count  output  LEN_W  number of terms in the frame.
- out_ovf  output  1  accumulator overflowed at least once during the frame.

Behaviour:
- Reset is asynchronous and active-high. During reset:
  - state=ACC; acc, cnt and ovf_acc cleared.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - in_ready=1 once rst deasserts.
- in_ready is combinational: in_ready = (state==ACC). It does not depend on in_valid.
- Accept = in_valid && in_ready.
- States: ACC and HOLD.
- ACC, on accept:
  - sum = acc + zero_extend(in_prod), computed ACC_W+1 bits wide.
  - Carry out sets the frame overflow: ovf_next = ovf_acc | carry.
  - Without SATURATE_EN the ACC_W-bit result wraps.
  - cnt_next = cnt+1.
- ACC, frame end: when the accept carries in_last=1, or cnt_next == 2^LEN_W-1 (forced termination):
  - out_sum <= the ACC_W-bit result, out_count <= cnt_next, out_ovf <= ovf_next, out_valid <= 1.
  - acc, cnt and ovf_acc cleared.
  - Next state HOLD.
- ACC, otherwise: acc, cnt and ovf_acc are updated and the block stays in ACC.
- ACC, no accept: all registers hold.
- Latency: out_valid rises on the clock edge that accepts the terminating term, i.e. visible the cycle after the final handshake.
- HOLD:
  - in_ready=0.
  - out_* stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid <= 0, next state ACC.
  - out_sum, out_count and out_ovf keep their last values after the handshake; they are not cleared.
- Throughput: one bubble cycle per frame (the cycle spent in HOLD).
- Single-term frame (in_last on the first accept): out_count=1, out_sum=in_prod.
- in_valid=0 for any number of cycles mid-frame: the partial frame is retained indefinitely.
- in_last while in_valid=0 is ignored.
- Reset mid-frame or mid-HOLD: the partial frame is discarded, out_valid drops immediately, and the next accepted term starts a new frame.
- No back-to-back frame overlap: a new frame's first term cannot be accepted in the same cycle as the out handshake.

Optional Feature:
- Macro: APPROX_ACC_SATURATE_EN.
- Defined: on carry out, the running acc clamps to {ACC_W{1'b1}} and stays clamped for the rest of the frame; out_sum for such a frame is all-ones.
- Undefined: the accumulator wraps modulo 2^ACC_W.
- out_ovf is set identically in both builds.

Test Plan:
- Reset, then frame of 3 products 0x0010, 0x0100, 0xFFFF (last on third), out_ready=1 -> one out_valid pulse, out_sum=0x01010F, out_count=3, out_ovf=0; in_ready=0 for exactly one cycle.
- Single term 0x1234 with in_last=1, out_ready=0 for 5 cycles -> out_valid held with out_sum=0x001234, out_count=1; in_ready=0 throughout; the next frame is accepted the cycle after out_ready=1.
- ACC_W=16, two terms 0xFFFF and 0x0002:
  - default build -> out_sum=0x0001, out_ovf=1.
  - APPROX_ACC_SATURATE_EN build -> out_sum=0xFFFF, out_ovf=1.
- LEN_W=3, 10 consecutive terms of 0x0001 with no in_last -> first frame forced at 7 terms (out_sum=7, out_count=7); the remaining 3 terms accumulate and complete with in_last on the 10th term (out_count=3).
- Random in_valid gaps (50%) and random out_ready stalls over 1000 frames vs. a reference sum model -> every frame's out_sum, out_count and out_ovf match; no term is dropped or duplicated.
- Assert rst for 1 cycle after 2 terms of a frame (asynchronous, mid-cycle) -> out_valid=0 immediately and all outputs 0; a following 1-term frame of 0x0005 gives out_sum=5, out_count=1.
